// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared seven-segment pattern constants and sampler state encoding
package seg_pkg;

  // Segment patterns, active-high, bit0=a .. bit6=g
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Value reported for a pattern that matches no digit
  localparam logic [3:0] VAL_ERR = 4'hF;

  // Sampler: WAIT for a one-hot strobe, SETTLE while counting, LOCKED once captured
  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } sampler_state_t;

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational seven-segment pattern to digit lookup
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       blank,
  output logic       err
);

  // Map a segment pattern to its digit; all-off is a blank, anything else is an error
  always_comb begin
    value = 4'd0;
    blank = 1'b0;
    err   = 1'b0;
    case (pattern)
      SEG_0:     value = 4'd0;
      SEG_1:     value = 4'd1;
      SEG_2:     value = 4'd2;
      SEG_3:     value = 4'd3;
      SEG_4:     value = 4'd4;
      SEG_5:     value = 4'd5;
      SEG_6:     value = 4'd6;
      SEG_7:     value = 4'd7;
      SEG_8:     value = 4'd8;
      SEG_9:     value = 4'd9;
      SEG_BLANK: blank = 1'b1;
      default: begin
        value = VAL_ERR;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - samples a multiplexed seven-segment display and emits decoded frames
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  input  logic                    frame_ready,
  output logic                    frame_valid,
  output logic [4*NUM_DIGITS-1:0] frame_digits,
  output logic [NUM_DIGITS-1:0]   frame_blank,
  output logic [NUM_DIGITS-1:0]   frame_err,
  output logic                    overrun
);

  localparam logic [7:0] STABLE_TGT = 8'(STABLE_CYCLES);

  logic [6:0]              seg_s1, seg_s2, seg_prev;
  logic [NUM_DIGITS-1:0]   dig_s1, dig_s2, dig_prev;

  sampler_state_t          state, state_n;
  logic [7:0]              cnt, cnt_n;
  logic                    capture;
  logic                    one_hot;
  logic                    changed;

  logic [3:0]              dec_value;
  logic                    dec_blank;
  logic                    dec_err;

  logic [NUM_DIGITS-1:0]   mask;
  logic                    frame_complete;
  logic [4*NUM_DIGITS-1:0] slot_digits;
  logic [NUM_DIGITS-1:0]   slot_blank;
  logic [NUM_DIGITS-1:0]   slot_err;

  assign one_hot        = $onehot(dig_s2);
  assign changed        = ({dig_s2, seg_s2} != {dig_prev, seg_prev});
  assign frame_complete = &mask;

  seg_pattern_decode u_decode (
    .pattern (seg_s2),
    .value   (dec_value),
    .blank   (dec_blank),
    .err     (dec_err)
  );

  // Two-flop synchronizers plus a one-cycle history used to detect changes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1   <= '0;
      seg_s2   <= '0;
      seg_prev <= '0;
      dig_s1   <= '0;
      dig_s2   <= '0;
      dig_prev <= '0;
    end else begin
      seg_s1   <= seg_in;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      dig_s1   <= dig_en;
      dig_s2   <= dig_s1;
      dig_prev <= dig_s2;
    end
  end

  // Sampler state and run-length counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_WAIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // cnt holds how many consecutive cycles the current one-hot pattern has been seen;
  // capture fires on the edge that completes the STABLE_CYCLES-th cycle
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    capture = 1'b0;
    if (!one_hot) begin
      state_n = ST_WAIT;
      cnt_n   = '0;
    end else if (state == ST_WAIT || changed) begin
      state_n = ST_SETTLE;
      cnt_n   = 8'd1;
    end else if (state == ST_SETTLE) begin
      cnt_n = cnt + 8'd1;
      if (cnt_n == STABLE_TGT) begin
        capture = 1'b1;
        state_n = ST_LOCKED;
      end
    end
  end

  // Slot storage and captured-mask; a completed frame always empties the mask
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask        <= '0;
      slot_digits <= '0;
      slot_blank  <= '0;
      slot_err    <= '0;
    end else begin
      mask <= (frame_complete ? '0 : mask) | (capture ? dig_s2 : '0);
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && dig_s2[i]) begin
          slot_digits[4*i +: 4] <= dec_value;
          slot_blank[i]         <= dec_blank;
          slot_err[i]           <= dec_err;
        end
      end
    end
  end

  // Output handshake: transfer a completed frame when the output is free, else drop it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_valid  <= 1'b0;
      frame_digits <= '0;
      frame_blank  <= '0;
      frame_err    <= '0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (frame_complete) begin
        if (!frame_valid || frame_ready) begin
          frame_valid  <= 1'b1;
          frame_digits <= slot_digits;
          frame_blank  <= slot_blank;
          frame_err    <= slot_err;
        end else begin
          overrun <= 1'b1;
        end
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end
    end
  end

endmodule
